uart_tx: RTL and testbench

//  UART transmitter: serialises one DATA_BITS-wide word per frame onto the idle-high TX line.
//  - Frame order: start (0), data LSB first, optional parity, stop bit(s) (1).
//  - Pairs with UART_RX on the opposite end of the link, using the same bit timing.
//  - Fed by a valid/ready handshake from the host or a FIFO.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and line levels.
// Used by both the transmitter and the receiver side of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   UART_CLKS_PER_BIT_DEF = 10417;  // 100 MHz / 9600 baud
    localparam logic UART_START_BIT        = 1'b0;
    localparam logic UART_STOP_BIT         = 1'b1;
    localparam logic UART_IDLE_LVL         = 1'b1;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and flags the last cycle of each bit.
// A clear restarts the period so a new frame is aligned to its accept edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB first, optional parity, 1 or 2 stop bits.
// Every output is a flop, so TX never sees a combinational path from the host inputs.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TX,
    output logic                 busy,
    output logic                 done
);

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 parity_q;
    logic                 tx_q, busy_q, done_q, ready_q;
    logic                 accept, tick;

    assign accept   = (state_q == ST_IDLE) && ready_q && tx_valid;
    assign tx_ready = ready_q;
    assign TX       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= tx_en;
                    if (accept) begin
                        shreg_q    <= tx_data;
                        parity_q   <= uart_parity(8'(tx_data), ODD);
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        tx_q       <= UART_START_BIT;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: if (tick) begin
                    tx_q    <= shreg_q[0];
                    state_q <= ST_DATA;
                end
                ST_DATA: if (tick) begin
                    shreg_q   <= shreg_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
                        end else begin
                            tx_q    <= UART_STOP_BIT;
                            state_q <= ST_STOP;
                        end
                    end else begin
                        // Present the next bit now, since the shift lands on this same edge.
                        tx_q <= shreg_q[1];
                    end
                end
                ST_PARITY: if (tick) begin
                    tx_q    <= UART_STOP_BIT;
                    state_q <= ST_STOP;
                end
                ST_STOP: if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= tx_en;
                        state_q <= ST_IDLE;
                    end else begin
                        stop_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    tx_q    <= UART_IDLE_LVL;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 instance with a bit-centre sampling receiver and scoreboard,
// plus even/odd parity instances with two stop bits.
module tb_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n, tx_en, tx_valid, valid_p;
    logic [7:0] tx_data;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_ready, b_tx, b_busy, b_done;
    logic       c_ready, c_tx, c_busy, c_done;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       mon_en;
    logic [7:0] mon_w;
    logic       seen;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(a_ready), .TX(a_tx), .busy(a_busy), .done(a_done)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_valid(valid_p), .tx_data(tx_data),
        .tx_ready(b_ready), .TX(b_tx), .busy(b_busy), .done(b_done)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_valid(valid_p), .tx_data(tx_data),
        .tx_ready(c_ready), .TX(c_tx), .busy(c_busy), .done(c_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            tick(1);
            if (a_done === 1'b1) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Receiver model: samples TX of the 8N1 instance at each bit centre.
    always begin
        @(negedge clk);
        if (mon_en === 1'b1 && rst_n === 1'b1 && a_tx === 1'b0) begin
            tick(CPB / 2 - 1);
            check("mon_start", 32'(a_tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                tick(CPB);
                mon_w[i] = a_tx;
            end
            tick(CPB);
            check("mon_stop", 32'(a_tx), 32'd1);
            check("mon_have_exp", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("mon_data", 32'(mon_w), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tx_en = 1'b0; tx_valid = 1'b0; valid_p = 1'b0; tx_data = '0; mon_en = 1'b1;
        seen = 1'b0;
        tick(2);
        check("rst_tx",    32'(a_tx),    32'd1);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_tx_b",  32'(b_tx),    32'd1);
        tx_en = 1'b1;
        tick(1);
        check("rst_ready_held", 32'(a_ready), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("rel_ready",   32'(a_ready), 32'd1);
        check("rel_ready_b", 32'(b_ready), 32'd1);

        // Single frame 0xA5: done exactly 160 cycles after the accept edge.
        tx_data = 8'hA5; tx_valid = 1'b1; exp_q.push_back(8'hA5);
        tick(1);
        tx_valid = 1'b0;
        check("acc_tx",    32'(a_tx),    32'd0);
        check("acc_busy",  32'(a_busy),  32'd1);
        check("acc_ready", 32'(a_ready), 32'd0);
        tick(159);
        check("pre_done", 32'(a_done), 32'd0);
        tick(1);
        check("done_160",   32'(a_done),  32'd1);
        check("done_busy",  32'(a_busy),  32'd0);
        check("done_ready", 32'(a_ready), 32'd1);

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        tx_data = 8'h00; tx_valid = 1'b1; exp_q.push_back(8'h00);
        tick(1);
        check("b2b_busy1", 32'(a_busy), 32'd1);
        tx_data = 8'hFF; exp_q.push_back(8'hFF);
        wait_done("b2b_done1", 200);
        check("b2b_idle_hi", 32'(a_tx), 32'd1);
        tick(1);
        check("b2b_start", 32'(a_tx),   32'd0);
        check("b2b_busy2", 32'(a_busy), 32'd1);
        tx_valid = 1'b0;
        wait_done("b2b_done2", 200);

        // Parity 0x07: even -> 1, odd -> 0; two stop bits give a 192-cycle frame.
        tick(2);
        tx_data = 8'h07; valid_p = 1'b1;
        tick(1);
        valid_p = 1'b0;
        check("par_start", 32'(b_tx),   32'd0);
        check("par_busy",  32'(b_busy), 32'd1);
        tick(152);
        check("par_even", 32'(b_tx), 32'd1);
        check("par_odd",  32'(c_tx), 32'd0);
        tick(28);
        check("par_stop2", 32'(b_tx),   32'd1);
        check("par_busy2", 32'(b_busy), 32'd1);
        tick(11);
        check("par_pre_done", 32'(b_done), 32'd0);
        tick(1);
        check("par_done_192", 32'(b_done), 32'd1);
        check("par_done_odd", 32'(c_done), 32'd1);

        // tx_en dropped mid-frame: frame completes, no new accept until re-enabled.
        tick(2);
        tx_data = 8'h3C; tx_valid = 1'b1; exp_q.push_back(8'h3C);
        tick(1);
        tx_valid = 1'b0;
        tick(49);
        tx_en = 1'b0;
        wait_done("en_done", 200);
        tx_data = 8'h99; tx_valid = 1'b1;
        tick(40);
        check("en_off_ready", 32'(a_ready), 32'd0);
        check("en_off_busy",  32'(a_busy),  32'd0);
        tx_en = 1'b1; exp_q.push_back(8'h99);
        tick(1);
        check("en_on_ready", 32'(a_ready), 32'd1);
        check("en_on_idle",  32'(a_busy),  32'd0);
        tick(1);
        check("en_on_acc", 32'(a_busy), 32'd1);
        tx_valid = 1'b0;
        wait_done("en_done2", 200);

        // Reset during data bit 3 of 0xC3 (bit 3 = 0): frame dropped, no done.
        tick(2);
        mon_en = 1'b0;
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(70);
        check("mid_bit3", 32'(a_tx), 32'd0);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_tx",    32'(a_tx),    32'd1);
        check("mid_rst_busy",  32'(a_busy),  32'd0);
        check("mid_rst_done",  32'(a_done),  32'd0);
        check("mid_rst_ready", 32'(a_ready), 32'd0);
        rst_n = 1'b1; mon_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (a_done === 1'b1) seen = 1'b1;
        end
        check("mid_no_done",   32'(seen),    32'd0);
        check("mid_ready_ret", 32'(a_ready), 32'd1);
        tx_data = 8'h5A; tx_valid = 1'b1; exp_q.push_back(8'h5A);
        tick(1);
        tx_valid = 1'b0;
        wait_done("final_done", 200);
        tick(20);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
